// File: rtl/alu_pkg.sv
// Shared constants for the ALU word sequencer: slice opcodes, chunk width, FSM states.
package alu_pkg;

   localparam int CHUNK_W = 8;

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_BMA = 3'b001;
   localparam logic [2:0] OP_AMB = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_AND = 3'b110;
   localparam logic [2:0] OP_PRE = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } seq_state_t;

endpackage

// File: rtl/cla_combine.sv
// Two-group look-ahead carry: carry into the high slice and carry out of the chunk.
module cla_combine (
   input  logic [1:0] g,
   input  logic [1:0] p,
   input  logic       cin,
   output logic       cmid,
   output logic       cout
);

   assign cmid = g[0] | (p[0] & cin);
   assign cout = g[1] | (p[1] & cmid);

endmodule

// File: rtl/alu_word_sequencer.sv
// Steps a wide operand through one 8-bit pair of 4-bit ALU slices, one chunk per
// cycle, carrying the look-ahead carry between chunks.
//
// state | meaning
// IDLE  | waiting for an operand word, in_ready high, slice inputs zero
// RUN   | driving chunk r_idx into the slices and capturing its result
// HOLD  | result word valid, waiting for out_ready
module alu_word_sequencer
   import alu_pkg::*;
#(
   parameter int NCHUNK = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHUNK_W*NCHUNK-1:0]   in_a,
   input  logic [CHUNK_W*NCHUNK-1:0]   in_b,
   input  logic [2:0]                  in_op,
   input  logic                        in_cin,
   output logic [CHUNK_W-1:0]          sl_a,
   output logic [CHUNK_W-1:0]          sl_b,
   output logic [2:0]                  sl_s,
   output logic                        sl_cin,
   output logic                        sl_cmid,
   input  logic [CHUNK_W-1:0]          sl_f,
   input  logic [1:0]                  sl_g,
   input  logic [1:0]                  sl_p,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHUNK_W*NCHUNK-1:0]   out_f,
   output logic                        out_cout
);

   localparam int W     = CHUNK_W * NCHUNK;
   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic              r_carry;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [2:0]        r_op;
   logic [W-1:0]      r_f;
   logic              r_cout;
   logic              r_valid;
   logic              w_cmid;
   logic              w_c8;
   logic              w_last;

   assign w_last = (r_idx == LAST_IDX);

   cla_combine u_cla (
      .g    (sl_g),
      .p    (sl_p),
      .cin  (r_carry),
      .cmid (w_cmid),
      .cout (w_c8)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = HOLD;
         HOLD:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Slice inputs are only driven while a chunk is in flight.
   always_comb begin
      in_ready = 1'b0;
      sl_a     = '0;
      sl_b     = '0;
      sl_s     = '0;
      sl_cin   = 1'b0;
      sl_cmid  = 1'b0;
      unique case (r_state)
         IDLE: in_ready = rst_n;
         RUN: begin
            sl_a    = r_a[int'(r_idx)*CHUNK_W +: CHUNK_W];
            sl_b    = r_b[int'(r_idx)*CHUNK_W +: CHUNK_W];
            sl_s    = r_op;
            sl_cin  = r_carry;
            sl_cmid = w_cmid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_f     <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_op    <= in_op;
                  r_carry <= in_cin;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_f[int'(r_idx)*CHUNK_W +: CHUNK_W] <= sl_f;
               if (w_last) begin
                  r_cout  <= w_c8;
                  r_valid <= 1'b1;
               end else begin
                  r_carry <= w_c8;
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) r_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_f     = r_f;
   assign out_cout  = r_cout;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a behavioural pair of 4-bit slices.
module tb_alu_word_sequencer;
   import alu_pkg::*;

   localparam int NCHUNK = 4;
   localparam int W      = 8 * NCHUNK;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [2:0]    in_op;
   logic          in_cin;
   logic [7:0]    sl_a;
   logic [7:0]    sl_b;
   logic [2:0]    sl_s;
   logic          sl_cin;
   logic          sl_cmid;
   logic [7:0]    sl_f;
   logic [1:0]    sl_g;
   logic [1:0]    sl_p;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_f;
   logic          out_cout;

   int n_asserts = 0;
   int n_fail    = 0;
   int lat;
   logic          rec_cin [16];
   logic [2:0]    rec_s   [16];
   logic [W-1:0]  held_f;
   logic          held_cout;

   always #5 clk = ~clk;

   alu_word_sequencer #(.NCHUNK(NCHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_cin    (in_cin),
      .sl_a      (sl_a),
      .sl_b      (sl_b),
      .sl_s      (sl_s),
      .sl_cin    (sl_cin),
      .sl_cmid   (sl_cmid),
      .sl_f      (sl_f),
      .sl_g      (sl_g),
      .sl_p      (sl_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_f     (out_f),
      .out_cout  (out_cout)
   );

   // One 4-bit slice: returns {g, p, f[3:0]}.
   function automatic logic [5:0] nib(input logic [3:0] a, input logic [3:0] b,
                                      input logic [2:0] s, input logic c);
      logic [3:0] aa, bb, f;
      logic [4:0] sum, gen;
      logic       g, p;
      aa = a; bb = b; f = 4'h0; g = 1'b0; p = 1'b0;
      case (s)
         OP_CLR: begin f = 4'h0; g = 1'b0; p = 1'b0; end
         OP_PRE: begin f = 4'hF; g = 1'b0; p = 1'b1; end
         OP_XOR: f = a ^ b;
         OP_OR:  f = a | b;
         OP_AND: f = a & b;
         default: begin
            if (s == OP_BMA) aa = ~a;
            if (s == OP_AMB) bb = ~b;
            gen = {1'b0, aa} + {1'b0, bb};
            sum = gen + {4'h0, c};
            f   = sum[3:0];
            g   = gen[4];
            p   = &(aa | bb);
         end
      endcase
      return {g, p, f};
   endfunction

   logic [5:0] w_lo, w_hi;
   assign w_lo = nib(sl_a[3:0], sl_b[3:0], sl_s, sl_cin);
   assign w_hi = nib(sl_a[7:4], sl_b[7:4], sl_s, sl_cmid);
   assign sl_f = {w_hi[3:0], w_lo[3:0]};
   assign sl_g = {w_hi[5], w_lo[5]};
   assign sl_p = {w_hi[4], w_lo[4]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic c);
      in_a = a; in_b = b; in_op = op; in_cin = c; in_valid = 1'b1;
   endtask

   // Called #1 after the accept edge; returns edges from accept to out_valid.
   task automatic collect(output int l);
      l = 1;
      while (!out_valid && l < 20) begin
         if (l <= 16) begin
            rec_cin[l-1] = sl_cin;
            rec_s[l-1]   = sl_s;
         end
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic c, output int l);
      int waited;
      waited = 0;
      while (!in_ready && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("ready_before_send", in_ready, 1);
      drive_in(a, b, op, c);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(l);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ack_in_ready", in_ready, 1);
      chk("ack_out_valid", out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);
      chk("rel_out_f", out_f, 32'h0);
      chk("rel_out_cout", out_cout, 0);
      chk("idle_sl_s", sl_s, 3'b000);
      chk("idle_sl_a", sl_a, 8'h00);

      send(32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0, lat);
      chk("add1_latency", lat, 5);
      chk("add1_valid", out_valid, 1);
      chk("add1_f", out_f, 32'h0000_0100);
      chk("add1_cout", out_cout, 0);
      ack();

      send(32'hFFFF_FFFF, 32'h0000_0000, OP_ADD, 1'b1, lat);
      chk("ripple_latency", lat, 5);
      chk("ripple_f", out_f, 32'h0000_0000);
      chk("ripple_cout", out_cout, 1);
      for (int i = 0; i < NCHUNK; i++) chk($sformatf("ripple_sl_cin%0d", i), rec_cin[i], 1);
      ack();

      chk("xor_idle_sl_s", sl_s, 3'b000);
      send(32'hA5A5_A5A5, 32'h0F0F_0F0F, OP_XOR, 1'b0, lat);
      chk("xor_latency", lat, 5);
      chk("xor_f", out_f, 32'hAAAA_AAAA);
      for (int i = 0; i < NCHUNK; i++) chk($sformatf("xor_sl_s%0d", i), rec_s[i], 3'b100);
      ack();
      chk("xor_after_sl_s", sl_s, 3'b000);

      send(32'h0000_0005, 32'h0000_0003, OP_AMB, 1'b1, lat);
      chk("amb_f", out_f, 32'h0000_0002);
      chk("amb_cout", out_cout, 1);
      ack();

      send(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0, lat);
      chk("bp_valid", out_valid, 1);
      chk("bp_f", out_f, 32'h2345_6789);
      chk("bp_cout", out_cout, 0);
      held_f = out_f; held_cout = out_cout;
      drive_in(32'h8000_0000, 32'h8000_0000, OP_ADD, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_f", out_f, 32'h2345_6789);
         chk("bp_hold_cout", out_cout, 0);
         chk("bp_hold_in_ready", in_ready, 0);
         chk("bp_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_accepted", in_ready, 0);
      collect(lat);
      chk("bp2_latency", lat, 5);
      chk("bp2_f", out_f, 32'h0000_0000);
      chk("bp2_cout", out_cout, 1);
      ack();

      drive_in(32'h1111_1111, 32'h2222_2222, OP_ADD, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_in_ready", in_ready, 0);
      chk("mid_partial_f", out_f[15:0], 16'h3333);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_f", out_f, 32'h0);
      chk("midrst_cout", out_cout, 0);
      chk("midrst_in_ready_low", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_output", out_valid, 0);
      end
      send(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b0, lat);
      chk("post_latency", lat, 5);
      chk("post_f", out_f, 32'h0000_0002);
      chk("post_cout", out_cout, 0);
      ack();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_word_sequencer.md
Name: alu_word_sequencer

Overview:
- Drives a pair of cascaded 4-bit 74381-style ALU slices (one 8-bit chunk) over multiple cycles to perform a wide-word operation.
- Consumes slice group generate/propagate (G/P) outputs as a 74182-style look-ahead carry unit: computes the inter-nibble carry and the inter-chunk carry, and stores the carry between cycles.
- Sits between the operand/opcode source (valid/ready) and the result sink (valid/ready). It is the carry-consuming end of the slice G/P interface.

Parameters:
- NCHUNK, 4, number of 8-bit chunks per word; word width W = 8*NCHUNK; legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  operand word valid
- in_ready  out  1  sequencer can accept a word
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_op  in  3  slice function select (S encoding, 000..111)
- in_cin  in  1  carry into chunk 0, low nibble
- sl_a  out  8  current chunk of A to slices ([3:0] low slice, [7:4] high slice)
- sl_b  out  8  current chunk of B to slices
- sl_s  out  3  function select to both slices
- sl_cin  out  1  carry into low slice
- sl_cmid  out  1  carry into high slice
- sl_f  in  8  slice results, combinational from sl_a/sl_b/sl_s/carries
- sl_g  in  2  group generate, [0] low slice, [1] high slice; active-high
- sl_p  in  2  group propagate, [0] low, [1] high; active-high
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_f  out  W  result word
- out_cout  out  1  carry out of top chunk

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE, chunk index=0, carry=0.
  - Operand registers, out_f, out_cout, and out_valid all 0.
  - in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-RUN or mid-HOLD abandons the word with no output.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_a, in_b, in_op; carry<=in_cin; idx<=0; go to RUN.
  - sl_a, sl_b, sl_s, sl_cin, and sl_cmid are all 0.
- RUN:
  - in_ready=0.
  - Slice drive: sl_a=A[8*idx+:8], sl_b=B[8*idx+:8], sl_s=op (held for the whole word), sl_cin=carry.
  - Inter-nibble carry: sl_cmid = sl_g[0] | (sl_p[0] & carry).
  - Each cycle, capture sl_f into out_f[8*idx+:8] and compute chunk carry-out c8 = sl_g[1] | (sl_p[1] & sl_cmid).
  - If idx<NCHUNK-1: carry<=c8, idx<=idx+1.
  - If idx=NCHUNK-1: out_cout<=c8, out_valid<=1, go to HOLD.
- Latency:
  - in handshake at cycle t gives out_valid=1 at cycle t+1+NCHUNK.
  - Throughput is one word per NCHUNK+2 cycles minimum.
- HOLD:
  - out_f, out_cout, and out_valid are stable.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - in_ready stays 0 (no overlap). out_ready is ignored outside HOLD.
- out_f bytes not yet written during RUN keep their previous value. out_f is only meaningful when out_valid=1.
- Carry rule is identical for all opcodes. Opcodes 000/111 (slice forces G/P) still propagate by the same formula. The sequencer never interprets op.
- NCHUNK=1: RUN lasts exactly one cycle.
- idx width is clog2(NCHUNK), minimum 1 bit. No wrap: the index never exceeds NCHUNK-1.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_CLR=000, OP_BMA=001, OP_AMB=010, OP_ADD=011, OP_XOR=100, OP_OR=101, OP_AND=110, OP_PRE=111
  - FSM state enum {IDLE, RUN, HOLD}
  - CHUNK_W=8 constant
- Sub-module cla_combine: 2-group look-ahead carry. Inputs g[1:0], p[1:0], cin; outputs cmid, cout. Purely combinational, instantiated once.

Test Plan:
- Bench slice model: per-nibble F=A op B with carry; for ADD, g=carry-generate and p=(A|B)-all-ones per nibble. All cases use NCHUNK=4.
- Reset and handshake: release reset -> in_ready=1, out_valid=0, out_f=0. Then ADD A=0x000000FF, B=0x00000001, cin=0 -> out_f=0x00000100, out_cout=0, out_valid exactly 5 cycles after accept.
- Full carry ripple: ADD A=0xFFFFFFFF, B=0x00000000, cin=1 -> out_f=0x00000000, out_cout=1; sl_cin=1 on every RUN cycle.
- Back-pressure: hold out_ready=0 for 10 cycles in HOLD -> out_f and out_cout stable, in_ready=0, a second in_valid is not accepted. out_ready=1 -> IDLE next cycle, second word then accepted.
- Non-arith op: XOR A=0xA5A5A5A5, B=0x0F0F0F0F -> out_f=0xAAAAAAAA. sl_s=100 on all four RUN cycles, 000 in IDLE.
- Reset mid-RUN: assert rst_n=0 at idx=2 -> next cycle state IDLE, out_valid=0, out_f=0. The subsequent ADD 1+1 gives out_f=0x00000002.
